// File: rtl/fetch_queue_pkg.sv
// Shared decode package: fetch entry bundle and MIPS opcode/funct/rt codes
// used by the fetch queue and its branch predecoder.
package fetch_queue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exception_instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_branch_predecode.sv
// Branch predecoder: flags words whose successor sits in a delay slot.
// Ports: instr (32-bit word in), is_branch (branch/jump detected).
module branch_predecode
  import fetch_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_branch
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];

  always_comb begin
    is_branch = 1'b0;
    unique case (1'b1)
      op == OP_BEQ,
      op == OP_BNE,
      op == OP_BLEZ,
      op == OP_BGTZ,
      op == OP_J,
      op == OP_JAL:
        is_branch = 1'b1;
      op == OP_REGIMM:
        is_branch = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                    (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      op == OP_SPECIAL:
        is_branch = (fn == FN_JR) || (fn == FN_JALR);
      default:
        is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO between fetch and decode with delay-slot tag.
// Ports: clk/resetn, in_* fetch beat (valid/ready), flush, out_* head
// entry toward decode (valid/ready), count = occupancy.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_addr_err,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pcplus4,
  output logic [31:0]              out_instr,
  output logic                     out_exception_instr,
  output logic                     out_in_delay_slot,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          prev_branch_q, prev_branch_d;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  logic empty, full, enq, deq;
  logic head_is_branch;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign enq = in_valid && !full && !flush;
  assign deq = !empty && out_ready && !flush;
  assign count = wr_ptr_q - rd_ptr_q;

  // Storage is never reset, so every head field is masked when empty.
  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign out_pc              = head.pc;
  assign out_pcplus4         = empty ? 32'd0 : head.pc + 32'd4;
  assign out_instr           = head.instr;
  assign out_exception_instr = head.exception_instr;
  assign out_in_delay_slot   = !empty && prev_branch_q;

  // A faulting fetch is carried as a NOP tagged with the exception.
  always_comb begin
    wr_entry.pc              = in_pc;
    wr_entry.instr           = in_addr_err ? 32'd0 : in_instr;
    wr_entry.exception_instr = in_addr_err;
  end

  branch_predecode u_predecode (
    .instr     (head.instr),
    .is_branch (head_is_branch)
  );

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    prev_branch_d = prev_branch_q;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      prev_branch_d = 1'b0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) begin
        rd_ptr_d      = rd_ptr_q + PW'(1);
        prev_branch_d = head_is_branch && !head.exception_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      prev_branch_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      prev_branch_q <= prev_branch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed beats queue expected head
// values; a negedge monitor pops and compares on every dequeue.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_addr_err;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;
  logic        out_exception_instr;
  logic        out_in_delay_slot;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] instr;
    logic        exc;
    logic        ds;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_pc               (in_pc),
    .in_instr            (in_instr),
    .in_addr_err         (in_addr_err),
    .flush               (flush),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_pcplus4         (out_pcplus4),
    .out_instr           (out_instr),
    .out_exception_instr (out_exception_instr),
    .out_in_delay_slot   (out_in_delay_slot),
    .count               (count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // pcp4 values are hand-written by callers so wrap is stated explicitly
  task automatic push(input logic [31:0] pc, input logic [31:0] pcp4,
                      input logic [31:0] instr, input logic err,
                      input logic ds);
    exp_t e;
    in_valid    = 1'b1;
    in_pc       = pc;
    in_instr    = instr;
    in_addr_err = err;
    e.pc    = pc;
    e.pcp4  = pcp4;
    e.instr = err ? 32'h0 : instr;
    e.exc   = err;
    e.ds    = ds;
    sb.push_back(e);
    cyc();
    in_valid    = 1'b0;
    in_addr_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dequeue: got pc %h expected none", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("deq_pc", out_pc, e.pc);
        chk("deq_pcplus4", out_pcplus4, e.pcp4);
        chk("deq_instr", out_instr, e.instr);
        chk("deq_exc", 32'(out_exception_instr), 32'(e.exc));
        chk("deq_ds", 32'(out_in_delay_slot), 32'(e.ds));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_instr    = '0;
    in_addr_err = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    repeat (2) cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_pcplus4", out_pcplus4, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_ds", 32'(out_in_delay_slot), 0);
    resetn = 1'b1;
    cyc();

    // first beat, no bypass
    chk("nobypass_valid", 32'(out_valid), 0);
    push(32'hBFC00000, 32'hBFC00004, 32'h24010001, 1'b0, 1'b0);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_count", 32'(count), 1);
    chk("first_pcplus4", out_pcplus4, 32'hBFC00004);
    chk("first_ds", 32'(out_in_delay_slot), 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("first_drained", 32'(out_valid), 0);

    // fill to full, 5th beat refused, drain in order
    push(32'h100, 32'h104, 32'h24020001, 1'b0, 1'b0);
    push(32'h104, 32'h108, 32'h24020002, 1'b0, 1'b0);
    push(32'h108, 32'h10C, 32'h24020003, 1'b0, 1'b0);
    push(32'h10C, 32'h110, 32'h24020004, 1'b0, 1'b0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_pc    = 32'h110;
    in_instr = 32'h24020005;
    cyc();
    in_valid = 1'b0;
    chk("full_refuse_count", 32'(count), 4);
    out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 0);
    chk("drain_in_ready", 32'(in_ready), 1);

    // BEQ then ADDU with a decode stall between them
    push(32'h120, 32'h124, 32'h10220003, 1'b0, 1'b0);
    push(32'h124, 32'h128, 32'h00221821, 1'b0, 1'b1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ds", 32'(out_in_delay_slot), 1);
      chk("stall_pc", out_pc, 32'h124);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("beq_drained", 32'(out_valid), 0);

    // J dequeued (tag set), 3 queued, flush with a beat presented
    push(32'h1F0, 32'h1F4, 32'h08000000, 1'b0, 1'b0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    push(32'h200, 32'h204, 32'h24000200, 1'b0, 1'b1);
    push(32'h204, 32'h208, 32'h24000204, 1'b0, 1'b0);
    push(32'h208, 32'h20C, 32'h24000208, 1'b0, 1'b0);
    chk("preflush_count", 32'(count), 3);
    chk("preflush_ds", 32'(out_in_delay_slot), 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h999;
    in_instr = 32'h24000999;
    sb.delete();
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_pc", out_pc, 0);
    push(32'h300, 32'h304, 32'h24000300, 1'b0, 1'b0);
    chk("postflush_ds", 32'(out_in_delay_slot), 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // address error, JR, REGIMM and JALR delay-slot tagging
    push(32'hBFC00002, 32'hBFC00006, 32'h10220003, 1'b1, 1'b0);
    chk("err_instr", out_instr, 0);
    chk("err_exc", 32'(out_exception_instr), 1);
    chk("err_pc", out_pc, 32'hBFC00002);
    out_ready = 1'b1;
    push(32'hBFC00004, 32'hBFC00008, 32'h24000000, 1'b0, 1'b0);
    push(32'h400, 32'h404, 32'h03E00008, 1'b0, 1'b0);
    push(32'h404, 32'h408, 32'h00000000, 1'b0, 1'b1);
    push(32'h408, 32'h40C, 32'h04210004, 1'b0, 1'b0);
    push(32'h40C, 32'h410, 32'h00000000, 1'b0, 1'b1);
    push(32'h410, 32'h414, 32'h04220004, 1'b0, 1'b0);
    push(32'h414, 32'h418, 32'h0040F809, 1'b0, 1'b0);
    push(32'h418, 32'h41C, 32'h00000000, 1'b0, 1'b1);
    push(32'hFFFFFFFC, 32'h00000000, 32'h24000000, 1'b0, 1'b0);
    repeat (3) cyc();
    out_ready = 1'b0;
    chk("mix_drained", 32'(count), 0);

    // steady push/pop at occupancy 2 across pointer wrap
    push(32'h1000, 32'h1004, 32'h24001000, 1'b0, 1'b0);
    push(32'h1004, 32'h1008, 32'h24001004, 1'b0, 1'b0);
    chk("stream_start_count", 32'(count), 2);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_t e;
      in_valid    = 1'b1;
      in_pc       = 32'h2000 + 32'(k * 4);
      in_instr    = 32'h24002000 + 32'(k);
      e.pc    = in_pc;
      e.pcp4  = 32'h2004 + 32'(k * 4);
      e.instr = in_instr;
      e.exc   = 1'b0;
      e.ds    = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      chk("stream_count", 32'(count), 2);
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b0;
    chk("stream_drained", 32'(count), 0);

    // reset in the middle of traffic
    push(32'h1F4, 32'h1F8, 32'h0C000000, 1'b0, 1'b0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    push(32'h600, 32'h604, 32'h24000600, 1'b0, 1'b1);
    push(32'h604, 32'h608, 32'h24000604, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_pc     = 32'h608;
    in_instr  = 32'h24000608;
    out_ready = 1'b1;
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_ds", 32'(out_in_delay_slot), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    push(32'h500, 32'h504, 32'h24000500, 1'b0, 1'b0);
    chk("postrst_count", 32'(count), 1);
    chk("postrst_pc", out_pc, 32'h500);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    repeat (2) cyc();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
